// File: rtl/select_control_pkg.sv
// ============================================================================
// Module      : select_control_pkg
// Description : Shared types for the select/encode control sequencer: state
//               enumeration, opcode constants, ALU encodings, decoded strobe
//               bundle and opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package select_control_pkg;

  // Controller states; IDLE and HALTED are the only non-running states
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd9
  } state_t;

  // Opcodes, taken from IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation encodings
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  // Execution behaviour of an opcode; unknown opcodes behave as nop
  typedef enum logic [2:0] {
    CL_NOP  = 3'd0,
    CL_ALU  = 3'd1,
    CL_ADDI = 3'd2,
    CL_LD   = 3'd3,
    CL_ST   = 3'd4,
    CL_HALT = 3'd5
  } op_class_t;

  // Full set of strobes driven toward the datapath
  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       baout;
    logic       pcout;
    logic       pcin;
    logic       incpc;
    logic       marin;
    logic       mdrin;
    logic       mdrout;
    logic       irin;
    logic       yin;
    logic       zin;
    logic       zlowout;
    logic       cout;
    logic       read;
    logic       write;
    logic [1:0] alu_op;
    logic       run;
  } ctrl_t;

  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_LD:                          cls = CL_LD;
      OP_ST:                          cls = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  cls = CL_ALU;
      OP_ADDI:                        cls = CL_ADDI;
      OP_HALT:                        cls = CL_HALT;
      default:                        cls = CL_NOP;
    endcase
    return cls;
  endfunction

  function automatic logic [1:0] alu_sel(input logic [4:0] op);
    logic [1:0] sel;
    case (op)
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/select_control_decode.sv
// ============================================================================
// Module      : select_control_decode
// Description : Purely combinational Moore decode from controller state and
//               latched opcode to the datapath strobe bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module select_control_decode
  import select_control_pkg::*;
(
  input  state_t     i_state,
  input  logic [4:0] i_op,
  input  logic       i_t1_first,
  output ctrl_t      o_ctrl
);

  op_class_t w_cls;

  assign w_cls = classify(i_op);

  // Strobe decode: everything defaults low, each state raises only its own set
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_T0: begin
        o_ctrl.pcout = 1'b1;
        o_ctrl.marin = 1'b1;
        o_ctrl.incpc = 1'b1;
        o_ctrl.zin   = 1'b1;
      end
      S_T1: begin
        o_ctrl.zlowout = 1'b1;
        o_ctrl.pcin    = i_t1_first;   // PC loads once even if the fetch waits
        o_ctrl.read    = 1'b1;
        o_ctrl.mdrin   = 1'b1;
      end
      S_T2: begin
        o_ctrl.mdrout = 1'b1;
        o_ctrl.irin   = 1'b1;
      end
      S_T3: begin
        o_ctrl.grb = 1'b1;
        o_ctrl.yin = 1'b1;
        if (w_cls == CL_LD || w_cls == CL_ST) begin
          o_ctrl.baout = 1'b1;
        end else if (w_cls == CL_ALU || w_cls == CL_ADDI) begin
          o_ctrl.rout = 1'b1;
        end
      end
      S_T4: begin
        o_ctrl.zin = 1'b1;
        if (w_cls == CL_ALU) begin
          o_ctrl.grc    = 1'b1;
          o_ctrl.rout   = 1'b1;
          o_ctrl.alu_op = alu_sel(i_op);
        end else begin
          // Immediate/displacement add for addi, ld and st
          o_ctrl.cout   = 1'b1;
          o_ctrl.alu_op = ALU_ADD;
        end
      end
      S_T5: begin
        o_ctrl.zlowout = 1'b1;
        if (w_cls == CL_LD || w_cls == CL_ST) begin
          o_ctrl.marin = 1'b1;
        end else begin
          o_ctrl.gra = 1'b1;
          o_ctrl.rin = 1'b1;
        end
      end
      S_T6: begin
        o_ctrl.mdrin = 1'b1;
        if (w_cls == CL_ST) begin
          o_ctrl.gra  = 1'b1;
          o_ctrl.rout = 1'b1;
        end else begin
          o_ctrl.read = 1'b1;
        end
      end
      S_T7: begin
        if (w_cls == CL_ST) begin
          o_ctrl.write = 1'b1;
        end else begin
          o_ctrl.mdrout = 1'b1;
          o_ctrl.gra    = 1'b1;
          o_ctrl.rin    = 1'b1;
        end
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
    o_ctrl.run = (i_state != S_IDLE) && (i_state != S_HALTED);
  end

endmodule

`default_nettype wire

// File: rtl/select_control_fsm.sv
// ============================================================================
// Module      : select_control_fsm
// Description : Fetch/execute control sequencer for a simple register-file
//               datapath. Holds the state register, latched opcode and
//               transition logic; strobes come from select_control_decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module select_control_fsm
  import select_control_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic [1:0]  alu_op,
  output logic        run
);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_op;
  logic       r_t1_first;
  op_class_t  w_ir_cls;
  op_class_t  w_op_cls;
  ctrl_t      w_ctrl;
  logic       w_unused_ir;

  assign w_ir_cls    = classify(IR[31:27]);
  assign w_op_cls    = classify(r_op);
  assign w_unused_ir = ^IR[26:0];   // operand fields are consumed by the datapath, not here

  // State register, opcode latch (taken as IR is loaded) and first-T1-cycle flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_t1_first <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_t1_first <= (w_next == S_T1) && (r_state != S_T1);
      if (r_state == S_T2) begin
        r_op <= IR[31:27];
      end
    end
  end

  // Next-state logic; mem_ready is only looked at in the three memory-wait states
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1:   if (mem_ready) w_next = S_T2;
      S_T2: begin
        case (w_ir_cls)
          CL_HALT: w_next = S_HALTED;
          CL_NOP:  w_next = S_T0;
          default: w_next = S_T3;
        endcase
      end
      S_T3:   w_next = S_T4;
      S_T4:   w_next = S_T5;
      S_T5: begin
        if (w_op_cls == CL_LD || w_op_cls == CL_ST) w_next = S_T6;
        else                                        w_next = S_T0;
      end
      S_T6: begin
        if (w_op_cls == CL_ST || mem_ready) w_next = S_T7;
      end
      S_T7: begin
        if (w_op_cls != CL_ST || mem_ready) w_next = S_T0;
      end
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  select_control_decode u_decode (
    .i_state    (r_state),
    .i_op       (r_op),
    .i_t1_first (r_t1_first),
    .o_ctrl     (w_ctrl)
  );

  assign Gra     = w_ctrl.gra;
  assign Grb     = w_ctrl.grb;
  assign Grc     = w_ctrl.grc;
  assign Rin     = w_ctrl.rin;
  assign Rout    = w_ctrl.rout;
  assign BAout   = w_ctrl.baout;
  assign PCout   = w_ctrl.pcout;
  assign PCin    = w_ctrl.pcin;
  assign IncPC   = w_ctrl.incpc;
  assign MARin   = w_ctrl.marin;
  assign MDRin   = w_ctrl.mdrin;
  assign MDRout  = w_ctrl.mdrout;
  assign IRin    = w_ctrl.irin;
  assign Yin     = w_ctrl.yin;
  assign Zin     = w_ctrl.zin;
  assign Zlowout = w_ctrl.zlowout;
  assign Cout    = w_ctrl.cout;
  assign Read    = w_ctrl.read;
  assign Write   = w_ctrl.write;
  assign alu_op  = w_ctrl.alu_op;
  assign run     = w_ctrl.run;

endmodule

`default_nettype wire

// File: tb/tb_select_control_fsm.sv
// ============================================================================
// Module      : tb_select_control_fsm
// Description : Self-checking bench for select_control_fsm: vector table,
//               directed memory-wait/halt/reset sequences and a randomized run
//               against a microprogram-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_select_control_fsm;

  // Observed output bit positions, {Gra ... Write, alu_op, run}
  localparam logic [21:0] B_GRA   = 22'd1 << 21;
  localparam logic [21:0] B_GRB   = 22'd1 << 20;
  localparam logic [21:0] B_GRC   = 22'd1 << 19;
  localparam logic [21:0] B_RIN   = 22'd1 << 18;
  localparam logic [21:0] B_ROUT  = 22'd1 << 17;
  localparam logic [21:0] B_BAOUT = 22'd1 << 16;
  localparam logic [21:0] B_PCOUT = 22'd1 << 15;
  localparam logic [21:0] B_PCIN  = 22'd1 << 14;
  localparam logic [21:0] B_INCPC = 22'd1 << 13;
  localparam logic [21:0] B_MARIN = 22'd1 << 12;
  localparam logic [21:0] B_MDRIN = 22'd1 << 11;
  localparam logic [21:0] B_MDROUT= 22'd1 << 10;
  localparam logic [21:0] B_IRIN  = 22'd1 << 9;
  localparam logic [21:0] B_YIN   = 22'd1 << 8;
  localparam logic [21:0] B_ZIN   = 22'd1 << 7;
  localparam logic [21:0] B_ZLOW  = 22'd1 << 6;
  localparam logic [21:0] B_COUT  = 22'd1 << 5;
  localparam logic [21:0] B_READ  = 22'd1 << 4;
  localparam logic [21:0] B_WRITE = 22'd1 << 3;
  localparam logic [21:0] B_RUN   = 22'd1;

  // Opcodes
  localparam logic [4:0] LD = 5'b00000, ST = 5'b00010, ADD = 5'b00011, SUB = 5'b00100;
  localparam logic [4:0] AND_ = 5'b00101, OR_ = 5'b00110, ADDI = 5'b01100;
  localparam logic [4:0] NOP = 5'b11010, HALT = 5'b11011, UNK = 5'b10101;

  // Expected strobe sets for each step of the instruction flow
  localparam logic [21:0] F0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam logic [21:0] F1  = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [21:0] F1W = B_ZLOW | B_READ | B_MDRIN | B_RUN;
  localparam logic [21:0] F2  = B_MDROUT | B_IRIN | B_RUN;
  localparam logic [21:0] A3  = B_GRB | B_ROUT | B_YIN | B_RUN;
  localparam logic [21:0] A4  = B_GRC | B_ROUT | B_ZIN | B_RUN;
  localparam logic [21:0] A5  = B_ZLOW | B_GRA | B_RIN | B_RUN;
  localparam logic [21:0] I4  = B_COUT | B_ZIN | B_RUN;
  localparam logic [21:0] M3  = B_GRB | B_BAOUT | B_YIN | B_RUN;
  localparam logic [21:0] M5  = B_ZLOW | B_MARIN | B_RUN;
  localparam logic [21:0] L6  = B_READ | B_MDRIN | B_RUN;
  localparam logic [21:0] L7  = B_MDROUT | B_GRA | B_RIN | B_RUN;
  localparam logic [21:0] S6  = B_GRA | B_ROUT | B_MDRIN | B_RUN;
  localparam logic [21:0] S7  = B_WRITE | B_RUN;

  logic        clock = 1'b0;
  logic        reset_n, start, mem_ready;
  logic [31:0] IR;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin;
  logic        MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write, run;
  logic [1:0]  alu_op;
  logic [21:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  select_control_fsm dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mem_ready(mem_ready), .IR(IR),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );

  assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin,
                MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write, alu_op, run};

  function automatic logic [31:0] ir_of(input logic [4:0] op);
    return {op, 27'h0918000};
  endfunction

  task automatic chk(input string name, input logic [21:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic chk_inv();
    n_cmp++;
    if ((int'(Gra) + int'(Grb) + int'(Grc)) > 1 || (Rin && (Rout || BAout)) || (Read && Write)) begin
      n_fail++;
      $display("FAIL invariant: got %06h required one-hot Gr*, no Rin with Rout/BAout, no Read with Write at %0t",
               obs, $time);
    end
  endtask

  // Apply inputs for the next rising edge, then land on the following falling edge
  task automatic drv(input logic s, input logic mr, input logic [4:0] op);
    start     = s;
    mem_ready = mr;
    IR        = ir_of(op);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    start     = 1'b0;
    mem_ready = 1'b0;
    reset_n   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n   = 1'b1;
  endtask

  // ---------------- reference model: per-instruction microprogram ----------------
  logic [21:0] p_out [8];
  bit          p_wait[8];
  int          p_len;

  task automatic load_fetch();
    p_out[0] = F0; p_wait[0] = 1'b0;
    p_out[1] = F1; p_wait[1] = 1'b1;
    p_out[2] = F2; p_wait[2] = 1'b0;
    p_len    = 3;
  endtask

  task automatic load_exec(input logic [4:0] op);
    for (int i = 3; i < 8; i++) p_wait[i] = 1'b0;
    p_len = 3;
    if (op >= ADD && op <= OR_) begin
      p_out[3] = A3;
      p_out[4] = A4 | (22'(op - ADD) << 1);   // add..or map to alu_op 0..3 in opcode order
      p_out[5] = A5;
      p_len    = 6;
    end else if (op == ADDI) begin
      p_out[3] = A3; p_out[4] = I4; p_out[5] = A5;
      p_len    = 6;
    end else if (op == LD || op == ST) begin
      p_out[3] = M3; p_out[4] = I4; p_out[5] = M5;
      if (op == LD) begin
        p_out[6] = L6; p_wait[6] = 1'b1;
        p_out[7] = L7;
      end else begin
        p_out[6] = S6;
        p_out[7] = S7; p_wait[7] = 1'b1;
      end
      p_len = 8;
    end
  endtask

  typedef struct {
    logic        st;
    logic        mr;
    logic [4:0]  op;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[38];

  initial begin
    int          mode;   // 0 idle, 1 running, 2 halted
    int          idx;
    bit          first;
    logic [4:0]  cur_op;
    logic [21:0] e;

    tbl[0]  = '{1, 1, ADD,  F0};  tbl[1]  = '{0, 1, ADD,  F1};
    tbl[2]  = '{0, 1, ADD,  F2};  tbl[3]  = '{0, 1, ADD,  A3};
    tbl[4]  = '{0, 0, ADD,  A4};  tbl[5]  = '{0, 1, ADD,  A5};
    tbl[6]  = '{0, 0, ADD,  F0};  tbl[7]  = '{0, 0, SUB,  F1};
    tbl[8]  = '{0, 0, SUB,  F1W}; tbl[9]  = '{0, 1, SUB,  F2};
    tbl[10] = '{0, 0, SUB,  A3};  tbl[11] = '{0, 1, SUB,  A4 | (22'd1 << 1)};
    tbl[12] = '{0, 0, SUB,  A5};  tbl[13] = '{0, 1, NOP,  F0};
    tbl[14] = '{0, 1, NOP,  F1};  tbl[15] = '{0, 1, NOP,  F2};
    tbl[16] = '{0, 1, NOP,  F0};  tbl[17] = '{0, 1, OR_,  F1};
    tbl[18] = '{0, 1, OR_,  F2};  tbl[19] = '{0, 1, OR_,  A3};
    tbl[20] = '{0, 1, OR_,  A4 | (22'd3 << 1)}; tbl[21] = '{0, 1, OR_, A5};
    tbl[22] = '{0, 1, ADDI, F0};  tbl[23] = '{0, 1, ADDI, F1};
    tbl[24] = '{0, 1, ADDI, F2};  tbl[25] = '{0, 1, ADDI, A3};
    tbl[26] = '{0, 1, ADDI, I4};  tbl[27] = '{0, 1, ADDI, A5};
    tbl[28] = '{0, 1, AND_, F0};  tbl[29] = '{0, 1, AND_, F1};
    tbl[30] = '{0, 1, AND_, F2};  tbl[31] = '{0, 1, AND_, A3};
    tbl[32] = '{0, 1, AND_, A4 | (22'd2 << 1)}; tbl[33] = '{0, 1, AND_, A5};
    tbl[34] = '{0, 1, UNK,  F0};  tbl[35] = '{0, 1, UNK,  F1};
    tbl[36] = '{0, 1, UNK,  F2};  tbl[37] = '{0, 1, UNK,  F0};

    // Reset state and idle hold
    start = 1'b0; mem_ready = 1'b1; IR = ir_of(ADD); reset_n = 1'b0;
    @(negedge clock);
    chk("reset_state", 22'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, ADD);
      chk("idle_hold", 22'd0);
    end

    // Vector table: add (one start pulse, back in T0 on cycle 7), sub with fetch wait, nop, or, addi, and, unknown
    for (int i = 0; i < 38; i++) begin
      drv(tbl[i].st, tbl[i].mr, tbl[i].op);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // ld with mem_ready low for three T6 cycles
    do_reset();
    drv(1, 1, LD); chk("ld_t0", F0);
    drv(0, 1, LD); chk("ld_t1", F1);
    drv(0, 1, LD); chk("ld_t2", F2);
    drv(0, 1, LD); chk("ld_t3", M3);
    drv(0, 1, LD); chk("ld_t4", I4);
    drv(0, 1, LD); chk("ld_t5", M5);
    drv(0, 0, LD); chk("ld_t6_0", L6);
    for (int i = 1; i < 4; i++) begin
      drv(0, 0, LD); chk($sformatf("ld_t6_%0d", i), L6);
    end
    drv(0, 1, LD); chk("ld_t7", L7);
    drv(0, 0, LD); chk("ld_done", F0);

    // st with two-cycle Write hold
    do_reset();
    drv(1, 1, ST); chk("st_t0", F0);
    drv(0, 1, ST); chk("st_t1", F1);
    drv(0, 1, ST); chk("st_t2", F2);
    drv(0, 1, ST); chk("st_t3", M3);
    drv(0, 1, ST); chk("st_t4", I4);
    drv(0, 1, ST); chk("st_t5", M5);
    drv(0, 1, ST); chk("st_t6", S6);
    drv(0, 0, ST); chk("st_t7_0", S7);
    drv(0, 0, ST); chk("st_t7_1", S7);
    drv(0, 1, ST); chk("st_done", F0);

    // halt is absorbing until reset
    do_reset();
    drv(1, 1, HALT); chk("halt_t0", F0);
    drv(0, 1, HALT); chk("halt_t1", F1);
    drv(0, 1, HALT); chk("halt_t2", F2);
    drv(0, 1, HALT); chk("halted", 22'd0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, ADD); chk("halted_start", 22'd0);
    end
    #2 reset_n = 1'b0;
    #1 chk("halt_reset", 22'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drv(0, 1, ADD); chk("halt_idle", 22'd0);
    drv(1, 1, ADD); chk("halt_restart", F0);

    // Asynchronous reset in T4 of addi
    do_reset();
    drv(1, 1, ADDI); chk("ar_t0", F0);
    drv(0, 1, ADDI); chk("ar_t1", F1);
    drv(0, 1, ADDI); chk("ar_t2", F2);
    drv(0, 1, ADDI); chk("ar_t3", A3);
    drv(0, 1, ADDI); chk("ar_t4", I4);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", 22'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drv(0, 1, ADDI); chk("ar_idle", 22'd0);

    // Randomized run against the microprogram model
    do_reset();
    load_fetch();
    mode = 0; idx = 0; first = 1'b0; cur_op = NOP;
    for (int c = 0; c < 10000; c++) begin
      if (mode == 1) begin
        e = p_out[idx];
        if (!first) e = e & ~B_PCIN;
      end else begin
        e = 22'd0;
      end
      chk("random", e);
      chk_inv();

      start     = ($urandom_range(0, 3) == 0);
      mem_ready = $urandom_range(0, 1) == 1;
      if (mode == 0 || (mode == 1 && idx == 0)) begin
        case ($urandom_range(0, 8))
          0: cur_op = LD;   1: cur_op = ST;   2: cur_op = ADD;  3: cur_op = SUB;
          4: cur_op = AND_; 5: cur_op = OR_;  6: cur_op = ADDI; 7: cur_op = NOP;
          default: begin
            cur_op = 5'($urandom);
            if (cur_op == HALT) cur_op = 5'b11111;
          end
        endcase
        IR = {cur_op, 27'($urandom)};
      end

      if (mode == 0) begin
        if (start) begin mode = 1; idx = 0; first = 1'b1; end
      end else if (mode == 1) begin
        if (p_wait[idx] && !mem_ready) begin
          first = 1'b0;
        end else begin
          first = 1'b1;
          if (idx == 2) begin
            if (IR[31:27] == HALT) mode = 2;
            else begin
              load_exec(IR[31:27]);
              idx = (p_len > 3) ? 3 : 0;
            end
          end else if (idx + 1 >= p_len) begin
            idx = 0;
          end else begin
            idx = idx + 1;
          end
        end
      end
      @(posedge clock);
      @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
